// File: rtl/enc_chan_sched.sv
// enc_chan_sched: TDM channel scheduler in front of a shared ADPCM encoder core.
// Recovers slot/frame timing from the serial-side slot clock and frame sync,
// hands one PCM byte per slot to the core together with channel, law and rate,
// keeps a code per channel and replays it one frame later on enc_i.
module enc_chan_sched #(
  parameter int NCH     = 8,
  parameter int CW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          law,
  input  logic [1:0]    RATE,
  input  logic [7:0]    enc_s,
  input  logic          enc_s_clk,
  input  logic          enc_s_fs,
  output logic          core_start,
  output logic [CW-1:0] core_ch,
  output logic [7:0]    core_s,
  output logic          core_law,
  output logic [1:0]    core_rate,
  input  logic          core_done,
  input  logic [4:0]    core_i,
  output logic [7:0]    enc_i,
  output logic          enc_i_clk,
  output logic          enc_i_fs,
  output logic          enc_error
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_e;

  // ---------------------------------------------------------------------
  // Serial-side synchronisation
  // ---------------------------------------------------------------------
  logic [1:0] sclk_q;
  logic [1:0] sfs_q;
  logic       sclk_prev_q;
  logic       sclk_sync;
  logic       fs_sync;
  logic       slot_tick;

  // Two-flop synchronisers plus one extra stage on the slot clock for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q      <= '0;
      sfs_q       <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0], enc_s_clk};
      sfs_q       <= {sfs_q[0], enc_s_fs};
      sclk_prev_q <= sclk_q[1];
    end
  end

  assign sclk_sync = sclk_q[1];
  assign fs_sync   = sfs_q[1];
  assign slot_tick = sclk_sync & ~sclk_prev_q;

  // ---------------------------------------------------------------------
  // Channel counter and frame-latched configuration
  // ---------------------------------------------------------------------
  logic [CW-1:0] ch_q, ch_d;
  logic          fv_q, fv_d;
  logic          law_q, law_d;
  logic [1:0]    rate_q, rate_d;
  logic          issue_tick;

  // Next channel / frame state; law and rate are only sampled on an fs tick
  always_comb begin
    ch_d   = ch_q;
    fv_d   = fv_q;
    law_d  = law_q;
    rate_d = rate_q;
    if (slot_tick) begin
      if (fs_sync) begin
        ch_d   = '0;
        fv_d   = 1'b1;
        law_d  = law;
        rate_d = RATE;
      end else if (ch_q == CW'(NCH - 1)) begin
        ch_d = '0;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  // A tick counts only once a frame has been seen (including the fs tick itself)
  assign issue_tick = slot_tick & fv_d;

  // Channel, frame-valid and configuration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_q   <= '0;
      fv_q   <= 1'b0;
      law_q  <= 1'b0;
      rate_q <= '0;
    end else begin
      ch_q   <= ch_d;
      fv_q   <= fv_d;
      law_q  <= law_d;
      rate_q <= rate_d;
    end
  end

  assign core_law  = law_q;
  assign core_rate = rate_q;

  // ---------------------------------------------------------------------
  // Per-channel code store and replay path
  // ---------------------------------------------------------------------
  logic [NCH-1:0][4:0] out_buf_q;
  logic                buf_we;
  logic [7:0]          enc_i_q, enc_i_d;
  logic                enc_i_fs_q, enc_i_fs_d;
  logic                enc_i_clk_q;

  // Replay last frame's code for the channel that the current slot now owns
  always_comb begin
    enc_i_d    = enc_i_q;
    enc_i_fs_d = enc_i_fs_q;
    if (issue_tick) begin
      enc_i_d    = {3'b000, out_buf_q[ch_d]};
      enc_i_fs_d = (ch_d == '0);
    end
  end

  // Replay registers; the output slot clock trails the synced input by one clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_i_q     <= '0;
      enc_i_fs_q  <= 1'b0;
      enc_i_clk_q <= 1'b0;
    end else begin
      enc_i_q     <= enc_i_d;
      enc_i_fs_q  <= enc_i_fs_d;
      enc_i_clk_q <= sclk_sync;
    end
  end

  assign enc_i     = enc_i_q;
  assign enc_i_fs  = enc_i_fs_q;
  assign enc_i_clk = enc_i_clk_q;

  // ---------------------------------------------------------------------
  // Core transaction FSM
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    core_s_q, core_s_d;
  logic [CW-1:0] core_ch_q, core_ch_d;

  // Next-state and strobes; an overrun drops the new sample but leaves the
  // in-flight transaction alone
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    core_s_d   = core_s_q;
    core_ch_d  = core_ch_q;
    buf_we     = 1'b0;
    core_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue_tick) begin
          core_s_d  = enc_s;
          core_ch_d = ch_d;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_d = STORE;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STORE: begin
        buf_we  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue_tick && (state_q != IDLE)) err_d = 1'b1;
  end

  // FSM state, timeout counter, sticky error and issued request fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      core_s_q  <= '0;
      core_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      core_s_q  <= core_s_d;
      core_ch_q <= core_ch_d;
    end
  end

  // Result write-back into the per-channel code store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf_q <= '0;
    end else if (buf_we) begin
      out_buf_q[core_ch_q] <= core_i;
    end
  end

  assign core_s    = core_s_q;
  assign core_ch   = core_ch_q;
  assign enc_error = err_q;

endmodule

// File: tb/tb_enc_chan_sched.sv
// Directed bench for enc_chan_sched with a behavioural encoder-core responder.
module tb_enc_chan_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       law = 1'b0;
  logic [1:0] RATE = 2'b00;
  logic [7:0] enc_s = 8'h00;
  logic       enc_s_clk = 1'b0;
  logic       enc_s_fs = 1'b0;
  logic       core_start;
  logic [2:0] core_ch;
  logic [7:0] core_s;
  logic       core_law;
  logic [1:0] core_rate;
  logic       core_done = 1'b0;
  logic [4:0] core_i = 5'h11;
  logic [7:0] enc_i;
  logic       enc_i_clk;
  logic       enc_i_fs;
  logic       enc_error;

  int n_chk = 0;
  int n_fail = 0;
  int resp_lat = 10;
  bit resp_en = 1'b1;
  int dbl = 0;
  logic prev_start = 1'b0;
  logic [13:0] log_q[$];   // {ch, s, law, rate} per observed start

  enc_chan_sched #(.NCH(8), .CW(3), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .law(law), .RATE(RATE), .enc_s(enc_s),
    .enc_s_clk(enc_s_clk), .enc_s_fs(enc_s_fs), .core_start(core_start),
    .core_ch(core_ch), .core_s(core_s), .core_law(core_law), .core_rate(core_rate),
    .core_done(core_done), .core_i(core_i), .enc_i(enc_i), .enc_i_clk(enc_i_clk),
    .enc_i_fs(enc_i_fs), .enc_error(enc_error)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] code_of(input logic [7:0] s);
    return s[4:0] ^ 5'h1F;
  endfunction

  // Start monitor
  always @(negedge clk) begin
    if (core_start === 1'b1) log_q.push_back({core_ch, core_s, core_law, core_rate});
    if (core_start === 1'b1 && prev_start === 1'b1) dbl++;
    prev_start = core_start;
  end

  // Core responder: answers code_of(core_s) resp_lat cycles after start
  always begin
    logic [7:0] rs;
    @(negedge clk);
    if (core_start === 1'b1 && resp_en) begin
      rs = core_s;
      repeat (resp_lat - 1) @(negedge clk);
      core_i = code_of(rs);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
  end

  task automatic slot(input logic fs, input logic [7:0] d, input int half);
    enc_s_fs = fs;
    enc_s = d;
    repeat (half) @(negedge clk);
    enc_s_clk = 1'b1;
    repeat (half) @(negedge clk);
    enc_s_clk = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if ({core_start, core_ch, core_s, core_law, core_rate} !== 15'd0) begin
      n_fail++; $display("FAIL reset_core: got %h want 0", {core_start, core_ch, core_s, core_law, core_rate}); end
    n_chk++; if ({enc_i, enc_i_clk, enc_i_fs} !== 10'd0) begin
      n_fail++; $display("FAIL reset_enc: got %h want 0", {enc_i, enc_i_clk, enc_i_fs}); end
    n_chk++; if (enc_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b want 0", enc_error); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal();
    do_reset();
    law = 1'b1; RATE = 2'b01; resp_lat = 10; resp_en = 1'b1;
    slot(1'b1, 8'hD5, 20);
    n_chk++; if (log_q.size() != 1) begin
      n_fail++; $display("FAIL normal_nstart: got %0d want 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {3'd0, 8'hD5, 1'b1, 2'b01}) begin
        n_fail++; $display("FAIL normal_issue: got %h want %h", log_q[0], {3'd0, 8'hD5, 1'b1, 2'b01}); end
    end
    n_chk++; if (enc_i !== 8'h00 || enc_i_fs !== 1'b1) begin
      n_fail++; $display("FAIL normal_first_out: got enc_i=%h fs=%b want 00/1", enc_i, enc_i_fs); end
    for (int c = 1; c < 8; c++) slot(1'b0, 8'(c * 17), 20);
    // next frame slot 0, done by hand to watch the regenerated slot clock
    enc_s_fs = 1'b1; enc_s = 8'h3C;
    repeat (20) @(negedge clk);
    enc_s_clk = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (enc_i_clk !== 1'b0) begin
      n_fail++; $display("FAIL normal_iclk_early: got %b want 0", enc_i_clk); end
    repeat (4) @(negedge clk);
    n_chk++; if (enc_i_clk !== 1'b1) begin
      n_fail++; $display("FAIL normal_iclk: got %b want 1", enc_i_clk); end
    repeat (14) @(negedge clk);
    enc_s_clk = 1'b0;
    n_chk++; if (enc_i !== 8'h0A || enc_i_fs !== 1'b1) begin
      n_fail++; $display("FAIL normal_replay: got enc_i=%h fs=%b want 0a/1", enc_i, enc_i_fs); end
    n_chk++; if (enc_error !== 1'b0) begin
      n_fail++; $display("FAIL normal_err: got %b want 0", enc_error); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    log_q.delete();
    slot(1'b1, 8'h40, 20);
    n_chk++; if (enc_i !== {3'b000, code_of(8'h3C)} || enc_i_fs !== 1'b1) begin
      n_fail++; $display("FAIL wrap_slot0: got enc_i=%h fs=%b want %h/1", enc_i, enc_i_fs, {3'b000, code_of(8'h3C)}); end
    for (int k = 1; k <= 8; k++) begin
      slot(1'b0, 8'h40 + 8'(k), 20);
      exp = (k == 8) ? {3'b000, code_of(8'h40)} : {3'b000, code_of(8'(k * 17))};
      n_chk++; if (enc_i !== exp || enc_i_fs !== (k == 8)) begin
        n_fail++; $display("FAIL wrap_out%0d: got enc_i=%h fs=%b want %h/%b", k, enc_i, enc_i_fs, exp, (k == 8)); end
    end
    n_chk++; if (log_q.size() != 9) begin
      n_fail++; $display("FAIL wrap_nstart: got %0d want 9", log_q.size()); end
    else begin
      for (int k = 0; k < 9; k++) begin
        n_chk++; if (log_q[k][13:11] !== 3'(k % 8)) begin
          n_fail++; $display("FAIL wrap_ch%0d: got %0d want %0d", k, log_q[k][13:11], k % 8); end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    law = 1'b0; RATE = 2'b10; resp_lat = 50; resp_en = 1'b1;
    slot(1'b1, 8'h81, 20);
    slot(1'b0, 8'h92, 20);
    resp_lat = 10;
    n_chk++; if (enc_error !== 1'b1) begin
      n_fail++; $display("FAIL overrun_err: got %b want 1", enc_error); end
    n_chk++; if (log_q.size() != 1) begin
      n_fail++; $display("FAIL overrun_drop: got %0d starts want 1", log_q.size()); end
    n_chk++; if (enc_i_fs !== 1'b0) begin
      n_fail++; $display("FAIL overrun_advance: got fs=%b want 0", enc_i_fs); end
    slot(1'b0, 8'hA3, 20);
    n_chk++; if (log_q.size() != 2 || log_q[$] !== {3'd2, 8'hA3, 1'b0, 2'b10}) begin
      n_fail++; $display("FAIL overrun_slot2: got n=%0d last=%h want 2/%h", log_q.size(), log_q[$], {3'd2, 8'hA3, 1'b0, 2'b10}); end
    for (int c = 3; c < 8; c++) slot(1'b0, 8'h00, 20);
    slot(1'b1, 8'h00, 20);
    n_chk++; if (enc_i !== 8'h1E) begin
      n_fail++; $display("FAIL overrun_inflight: got %h want 1e", enc_i); end
    slot(1'b0, 8'h00, 20);
    n_chk++; if (enc_i !== 8'h00) begin
      n_fail++; $display("FAIL overrun_dropped_ch1: got %h want 00", enc_i); end
    slot(1'b0, 8'h00, 20);
    n_chk++; if (enc_i !== 8'h1C) begin
      n_fail++; $display("FAIL overrun_ch2: got %h want 1c", enc_i); end
  endtask

  task automatic test_timeout();
    do_reset();
    law = 1'b1; RATE = 2'b00; resp_en = 1'b0;
    enc_s_fs = 1'b1; enc_s = 8'h55;
    repeat (20) @(negedge clk);
    enc_s_clk = 1'b1;
    repeat (250) @(negedge clk);
    n_chk++; if (enc_error !== 1'b0 || log_q.size() != 1) begin
      n_fail++; $display("FAIL timeout_early: got err=%b n=%0d want 0/1", enc_error, log_q.size()); end
    repeat (16) @(negedge clk);
    n_chk++; if (enc_error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err: got %b want 1", enc_error); end
    enc_s_clk = 1'b0;
    resp_en = 1'b1; resp_lat = 10;
    slot(1'b0, 8'h66, 20);
    n_chk++; if (log_q.size() != 2 || log_q[$][13:11] !== 3'd1) begin
      n_fail++; $display("FAIL timeout_next_issue: got n=%0d ch=%0d want 2/1", log_q.size(), log_q[$][13:11]); end
    for (int c = 2; c < 8; c++) slot(1'b0, 8'h00, 20);
    slot(1'b1, 8'h00, 20);
    n_chk++; if (enc_i !== 8'h00) begin
      n_fail++; $display("FAIL timeout_keep: got %h want 00", enc_i); end
    slot(1'b0, 8'h00, 20);
    n_chk++; if (enc_i !== 8'h19) begin
      n_fail++; $display("FAIL timeout_ch1: got %h want 19", enc_i); end
    n_chk++; if (enc_error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", enc_error); end
  endtask

  task automatic test_config();
    do_reset();
    law = 1'b0; RATE = 2'b11; resp_en = 1'b1; resp_lat = 10;
    slot(1'b1, 8'h01, 20);
    slot(1'b0, 8'h02, 20);
    slot(1'b0, 8'h03, 20);
    RATE = 2'b00; law = 1'b1;
    for (int c = 3; c < 8; c++) begin
      slot(1'b0, 8'(c), 20);
      n_chk++; if (core_rate !== 2'b11 || log_q[$][1:0] !== 2'b11 || core_law !== 1'b0) begin
        n_fail++; $display("FAIL config_hold%0d: got rate=%b lograte=%b law=%b want 11/11/0", c, core_rate, log_q[$][1:0], core_law); end
    end
    slot(1'b1, 8'h08, 20);
    n_chk++; if (core_rate !== 2'b00 || log_q[$][2:0] !== 3'b100) begin
      n_fail++; $display("FAIL config_apply: got rate=%b log=%b want 00/100", core_rate, log_q[$][2:0]); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    resp_en = 1'b0; law = 1'b1; RATE = 2'b01;
    enc_s_fs = 1'b1; enc_s = 8'h77;
    repeat (20) @(negedge clk);
    enc_s_clk = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if ({core_start, core_ch, core_s, core_law, core_rate} !== 15'd0) begin
      n_fail++; $display("FAIL midwait_core: got %h want 0", {core_start, core_ch, core_s, core_law, core_rate}); end
    n_chk++; if ({enc_i, enc_i_clk, enc_i_fs, enc_error} !== 11'd0) begin
      n_fail++; $display("FAIL midwait_enc: got %h want 0", {enc_i, enc_i_clk, enc_i_fs, enc_error}); end
    enc_s_clk = 1'b0; enc_s_fs = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    resp_en = 1'b1;
    log_q.delete();
    repeat (30) @(negedge clk);
    slot(1'b0, 8'h12, 20);
    n_chk++; if (log_q.size() != 0 || enc_i !== 8'h00) begin
      n_fail++; $display("FAIL midwait_no_start: got n=%0d enc_i=%h want 0/00", log_q.size(), enc_i); end
    slot(1'b1, 8'h34, 20);
    n_chk++; if (log_q.size() != 1 || log_q[$][13:3] !== {3'd0, 8'h34}) begin
      n_fail++; $display("FAIL midwait_first_fs: got n=%0d log=%h want 1/%h", log_q.size(), log_q[$][13:3], {3'd0, 8'h34}); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wrap();
    test_overrun();
    test_timeout();
    test_config();
    test_reset_mid_wait();
    n_chk++; if (dbl != 0) begin
      n_fail++; $display("FAIL start_width: got %0d multi-cycle starts want 0", dbl); end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
